// File: rtl/free_preg_allocator_if.sv
// rtl/free_preg_allocator_if.sv - rename/ROB-side bundle for the physical register free-list allocator
interface free_preg_allocator_if #(
    parameter int RENAME_WIDTH = 2,
    parameter int PW           = 6,
    parameter int FCW          = 6,
    parameter int CW           = 2
);
    logic [RENAME_WIDTH-1:0]          alloc_req;
    logic [RENAME_WIDTH-1:0]          alloc_grant;
    logic [RENAME_WIDTH-1:0][PW-1:0]  alloc_preg;
    logic [RENAME_WIDTH-1:0]          free_valid;
    logic [RENAME_WIDTH-1:0][PW-1:0]  free_preg;
    logic [CW-1:0]                    commit_alloc_cnt;
    logic                             flush;
    logic                             ready;
    logic [FCW-1:0]                   free_count;
    logic                             err;

    modport master (
        output alloc_req, free_valid, free_preg, commit_alloc_cnt, flush,
        input  alloc_grant, alloc_preg, ready, free_count, err
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, commit_alloc_cnt, flush,
        output alloc_grant, alloc_preg, ready, free_count, err
    );
endinterface

// File: rtl/free_preg_allocator.sv
// rtl/free_preg_allocator.sv - physical register free list with in-order lane grants, commit reclaim and flush rewind
module free_preg_allocator #(
    parameter int NUM_PREGS    = 64,
    parameter int NUM_AREGS    = 32,
    parameter int RENAME_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    free_preg_allocator_if.slave  bus
);
    localparam int PW    = $clog2(NUM_PREGS);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int IW    = $clog2(DEPTH);
    localparam int PTRW  = IW + 1;
    localparam int FCW   = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(RENAME_WIDTH + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state;
    logic [IW-1:0]           cnt;
    logic [PTRW-1:0]         wr_ptr;
    logic [PTRW-1:0]         spec_rd_ptr;
    logic [PTRW-1:0]         commit_rd_ptr;
    logic [PW-1:0]           entry [DEPTH];
    logic [FCW-1:0]          free_count;
    logic                    err;

    logic                    run_ok;
    logic [CW-1:0]           req_n;
    logic [CW-1:0]           grant_n;
    logic                    blocked;
    logic [PTRW-1:0]         in_flight;
    logic [PTRW-1:0]         commit_n;
    logic [PTRW-1:0]         spec_n;
    logic [PTRW-1:0]         wr_n;
    logic [RENAME_WIDTH-1:0] wr_en;
    logic [IW-1:0]           wr_idx [RENAME_WIDTH];
    logic                    err_set;

    assign run_ok         = rst && (state == ST_RUN) && !bus.flush;
    assign bus.ready      = (state == ST_RUN);
    assign bus.free_count = free_count;
    assign bus.err        = err;

    // Grants use only registered free_count, so same-cycle frees never feed a grant.
    always_comb begin
        req_n           = '0;
        grant_n         = '0;
        blocked         = 1'b0;
        bus.alloc_grant = '0;
        bus.alloc_preg  = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (bus.alloc_req[i]) begin
                req_n = req_n + CW'(1);
                if (run_ok && !blocked && (FCW'(req_n) <= free_count)) begin
                    bus.alloc_grant[i] = 1'b1;
                    bus.alloc_preg[i]  = entry[IW'(spec_rd_ptr + PTRW'(req_n) - PTRW'(1))];
                    grant_n            = req_n;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        err_set   = 1'b0;
        in_flight = spec_rd_ptr - commit_rd_ptr;
        commit_n  = commit_rd_ptr + PTRW'(bus.commit_alloc_cnt);
        if (PTRW'(bus.commit_alloc_cnt) > in_flight) begin
            err_set  = 1'b1;
            commit_n = spec_rd_ptr;
        end
        spec_n = bus.flush ? commit_n : spec_rd_ptr + PTRW'(grant_n);
        // Capacity is judged against the post-commit pointer so a commit and its stale free can share a cycle.
        wr_n  = wr_ptr;
        wr_en = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            wr_idx[i] = IW'(wr_n);
            if (bus.free_valid[i]) begin
                if ((wr_n - commit_n) >= PTRW'(DEPTH)) begin
                    err_set = 1'b1;
                end else begin
                    wr_en[i] = 1'b1;
                    wr_n     = wr_n + PTRW'(1);
                end
            end
        end
        if (state == ST_INIT) begin
            err_set = |bus.free_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_INIT;
            cnt           <= '0;
            wr_ptr        <= '0;
            spec_rd_ptr   <= '0;
            commit_rd_ptr <= '0;
            free_count    <= '0;
            err           <= 1'b0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + IW'(1);
            if (err_set) begin
                err <= 1'b1;
            end
            if (cnt == IW'(DEPTH - 1)) begin
                state      <= ST_RUN;
                wr_ptr     <= PTRW'(DEPTH);
                free_count <= FCW'(DEPTH);
            end
        end else begin
            wr_ptr        <= wr_n;
            spec_rd_ptr   <= spec_n;
            commit_rd_ptr <= commit_n;
            free_count    <= FCW'(wr_n - spec_n);
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                entry[cnt] <= PW'(NUM_AREGS) + PW'(cnt);
            end else begin
                for (int i = 0; i < RENAME_WIDTH; i++) begin
                    if (wr_en[i]) begin
                        entry[wr_idx[i]] <= bus.free_preg[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_free_preg_allocator.sv
// tb/tb_free_preg_allocator.sv - scoreboard bench for free_preg_allocator
module tb_free_preg_allocator;
    logic clk;
    logic rst;

    free_preg_allocator_if #(.RENAME_WIDTH(2), .PW(6), .FCW(6), .CW(2)) bus ();

    free_preg_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] g;
        logic [5:0] p0;
        logic [5:0] p1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_inputs();
        bus.alloc_req        = '0;
        bus.free_valid       = '0;
        bus.free_preg        = '0;
        bus.commit_alloc_cnt = '0;
        bus.flush            = 1'b0;
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] fv, input logic [5:0] fp0,
                        input logic [5:0] fp1, input logic [1:0] cac, input logic fl,
                        input logic [1:0] eg, input logic [5:0] ep0, input logic [5:0] ep1);
        exp_t e;
        bus.alloc_req        = req;
        bus.free_valid       = fv;
        bus.free_preg[0]     = fp0;
        bus.free_preg[1]     = fp1;
        bus.commit_alloc_cnt = cac;
        bus.flush            = fl;
        if (req != 2'b00) begin
            e.g  = eg;
            e.p0 = ep0;
            e.p1 = ep1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(2'b00, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b00, 6'd0, 6'd0);
        end
    endtask

    task automatic run_init();
        for (int i = 0; i < 32; i++) begin
            chk("init_ready_low", {31'd0, bus.ready}, 32'd0);
            idle(1);
        end
        chk("init_ready_high", {31'd0, bus.ready}, 32'd1);
        chk("init_free_count", {26'd0, bus.free_count}, 32'd32);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.alloc_req != 2'b00) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got grant %b with no expected entry", bus.alloc_grant);
            end else begin
                e = q.pop_front();
                if (bus.alloc_grant !== e.g) begin
                    bad++;
                    $display("FAIL grant: got %b expected %b (req %b)", bus.alloc_grant, e.g, bus.alloc_req);
                end else if (e.g[0] && bus.alloc_preg[0] !== e.p0) begin
                    bad++;
                    $display("FAIL preg0: got %0d expected %0d", bus.alloc_preg[0], e.p0);
                end else if (e.g[1] && bus.alloc_preg[1] !== e.p1) begin
                    bad++;
                    $display("FAIL preg1: got %0d expected %0d", bus.alloc_preg[1], e.p1);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_free_count", {26'd0, bus.free_count}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b1;
        run_init();

        // Flush rewinds to the committed point, honouring the same-cycle commit.
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b11, 6'd32, 6'd33);
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b11, 6'd34, 6'd35);
        chk("pre_flush_count", {26'd0, bus.free_count}, 32'd28);
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd1, 1'b1, 2'b00, 6'd0, 6'd0);
        chk("flush_count", {26'd0, bus.free_count}, 32'd31);
        step(2'b01, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b01, 6'd33, 6'd0);
        chk("post_flush_count", {26'd0, bus.free_count}, 32'd30);

        rst = 1'b0;
        idle(3);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
        chk("midrst_free_count", {26'd0, bus.free_count}, 32'd0);
        rst = 1'b1;
        run_init();

        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b11, 6'd32, 6'd33);
        chk("alloc2_count", {26'd0, bus.free_count}, 32'd30);
        for (int k = 0; k < 14; k++) begin
            step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b11, 6'(34 + 2 * k), 6'(35 + 2 * k));
        end
        chk("drain_count2", {26'd0, bus.free_count}, 32'd2);
        step(2'b10, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b10, 6'd0, 6'd62);
        chk("drain_count1", {26'd0, bus.free_count}, 32'd1);
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b01, 6'd63, 6'd0);
        chk("drain_count0", {26'd0, bus.free_count}, 32'd0);
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b00, 6'd0, 6'd0);

        for (int k = 0; k < 16; k++) begin
            step(2'b00, 2'b00, 6'd0, 6'd0, 2'd2, 1'b0, 2'b00, 6'd0, 6'd0);
        end
        chk("commit_all_err", {31'd0, bus.err}, 32'd0);

        // A free arriving at empty is not bypassed to the same-cycle request.
        step(2'b01, 2'b10, 6'd0, 6'd5, 2'd0, 1'b0, 2'b00, 6'd0, 6'd0);
        chk("free_at_empty_count", {26'd0, bus.free_count}, 32'd1);
        step(2'b01, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b01, 6'd5, 6'd0);
        chk("realloc_count", {26'd0, bus.free_count}, 32'd0);
        step(2'b00, 2'b00, 6'd0, 6'd0, 2'd1, 1'b0, 2'b00, 6'd0, 6'd0);

        for (int k = 0; k < 16; k++) begin
            step(2'b00, 2'b11, 6'(32 + 2 * k), 6'(33 + 2 * k), 2'd0, 1'b0, 2'b00, 6'd0, 6'd0);
        end
        chk("refill_count", {26'd0, bus.free_count}, 32'd32);
        chk("refill_err", {31'd0, bus.err}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            step(2'b01, (i > 0) ? 2'b01 : 2'b00, 6'(32 + ((i + 31) % 32)), 6'd0,
                 (i > 0) ? 2'd1 : 2'd0, 1'b0, 2'b01, 6'(32 + (i % 32)), 6'd0);
        end
        chk("wrap_count", {26'd0, bus.free_count}, 32'd31);
        step(2'b00, 2'b01, 6'd39, 6'd0, 2'd1, 1'b0, 2'b00, 6'd0, 6'd0);
        chk("wrap_full_count", {26'd0, bus.free_count}, 32'd32);
        chk("wrap_err", {31'd0, bus.err}, 32'd0);

        step(2'b00, 2'b01, 6'd7, 6'd0, 2'd0, 1'b0, 2'b00, 6'd0, 6'd0);
        chk("overflow_err", {31'd0, bus.err}, 32'd1);
        chk("overflow_count", {26'd0, bus.free_count}, 32'd32);
        idle(1);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);
        step(2'b11, 2'b00, 6'd0, 6'd0, 2'd0, 1'b0, 2'b11, 6'd40, 6'd41);
        chk("post_err_count", {26'd0, bus.free_count}, 32'd30);

        idle(2);
        chk("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
